// File: rtl/wt_pkg.sv
// Shared types and default widths for the write-through store buffer.
package wt_pkg;

    localparam int WT_ADDR_W = 10;
    localparam int WT_DATA_W = 32;
    localparam int WT_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/wt_fwd_lookup.sv
// Youngest-match search over buffered stores for load forwarding.
module wt_fwd_lookup #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [PTR_W-1:0]             wr_ptr,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_hit,
    output logic [DATA_W-1:0]            ld_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wr_ptr - PTR_W'(i);
            if (valid[idx] && addr[idx] == ld_addr) begin
                ld_hit  = 1'b1;
                ld_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/wt_write_buffer.sv
// Store buffer for the write-through path: in-order drain to memory
// over req/ack, with youngest-match forwarding to loads.
module wt_write_buffer
    import wt_pkg::*;
#(
    parameter int ADDR_W = WT_ADDR_W,
    parameter int DATA_W = WT_DATA_W,
    parameter int DEPTH  = WT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              buf_full,
    output logic              buf_empty,
    output logic [PTR_W:0]    buf_count,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data
);

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data_q;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]               count_q, count_d;
    drain_state_e                 state_q, state_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;

    logic push, pop, load;

    assign buf_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign buf_empty = (count_q == '0);
    assign buf_count = count_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign push = cpu_wr_req && !buf_full;
    assign pop  = (state_q == ISSUE) && mem_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        valid_d = valid_q;
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (mem_ack) state_d = GAP;
            GAP:     state_d = (count_q != '0) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Head is latched only on entry to ISSUE so it stays stable until ack.
    always_comb begin
        load        = (state_q != ISSUE) && (state_d == ISSUE);
        mem_addr_d  = load ? ent_addr_q[rd_ptr_q] : mem_addr_q;
        mem_wdata_d = load ? ent_data_q[rd_ptr_q] : mem_wdata_q;
    end

    always_comb begin
        mem_wr_req = (state_q == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= cpu_addr;
            ent_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    wt_fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd (
        .valid   (valid_q),
        .addr    (ent_addr_q),
        .data    (ent_data_q),
        .wr_ptr  (wr_ptr_q),
        .ld_addr (ld_addr),
        .ld_hit  (ld_hit),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_wt_write_buffer.sv
// Scoreboard bench for wt_write_buffer: stores queued on acceptance,
// compared against the memory port on each ack.
module tb_wt_write_buffer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          cpu_wr_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          buf_full;
    logic          buf_empty;
    logic [2:0]    buf_count;
    logic          mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;

    int n_cmp = 0;
    int n_bad = 0;
    ent_t sb[$];

    wt_write_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_wr_req (cpu_wr_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .buf_full   (buf_full),
        .buf_empty  (buf_empty),
        .buf_count  (buf_count),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        cpu_wr_req = 1'b1;
        cpu_addr   = a;
        cpu_wdata  = d;
        acc = (sb.size() < DEPTH);
        check("full_pre", buf_full, 64'(sb.size() == DEPTH));
        tick();
        cpu_wr_req = 1'b0;
        if (acc) sb.push_back('{a: a, d: d});
        check("count_store", buf_count, 64'(sb.size()));
    endtask

    task automatic ack_after(input int dly);
        int n;
        n = 0;
        while (mem_wr_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (mem_wr_req !== 1'b1 || sb.size() == 0) begin
            check("req_timeout", 64'(mem_wr_req), 64'd1);
            return;
        end
        repeat (dly) begin
            tick();
            check("req_hold", mem_wr_req, 1);
            check("addr_hold", mem_addr, sb[0].a);
        end
        mem_ack = 1'b1;
        check("mem_addr", mem_addr, sb[0].a);
        check("mem_wdata", mem_wdata, sb[0].d);
        tick();
        mem_ack = 1'b0;
        void'(sb.pop_front());
        check("gap_req", mem_wr_req, 0);
        check("count_pop", buf_count, 64'(sb.size()));
        tick();
        check("post_gap_req", mem_wr_req, 64'(sb.size() != 0));
    endtask

    initial begin
        rst        = 1'b0;
        cpu_wr_req = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        mem_ack    = 1'b0;
        ld_addr    = '0;
        #12;
        check("rst_req", mem_wr_req, 0);
        check("rst_empty", buf_empty, 1);
        check("rst_full", buf_full, 0);
        check("rst_count", buf_count, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mdata", mem_wdata, 0);
        rst = 1'b1;
        tick();

        // Reset while a write is being issued.
        store(10'h001, 32'hA1);
        store(10'h002, 32'hA2);
        store(10'h003, 32'hA3);
        check("t1_req", mem_wr_req, 1);
        #2 rst = 1'b0;
        #1;
        check("t1_req0", mem_wr_req, 0);
        check("t1_empty", buf_empty, 1);
        check("t1_count", buf_count, 0);
        check("t1_maddr", mem_addr, 0);
        sb.delete();
        #3 rst = 1'b1;
        tick();

        // Single store latency and drain.
        store(10'h010, 32'hDEADBEEF);
        check("t2_req_early", mem_wr_req, 0);
        tick();
        check("t2_req", mem_wr_req, 1);
        check("t2_addr", mem_addr, 10'h010);
        check("t2_data", mem_wdata, 32'hDEADBEEF);
        ack_after(3);
        check("t2_empty", buf_empty, 1);

        // Fill, refuse on full, refuse with same-cycle pop.
        for (int i = 0; i < 4; i++)
            store(AW'(10'h100 + i), DW'(32'hB0 + i));
        check("t3_full", buf_full, 1);
        store(10'h3FF, 32'hFF);
        check("t3_count4", buf_count, 4);
        check("t3_req", mem_wr_req, 1);
        cpu_wr_req = 1'b1;
        cpu_addr   = 10'h3FF;
        cpu_wdata  = 32'hFF;
        mem_ack    = 1'b1;
        check("t3_addr", mem_addr, sb[0].a);
        tick();
        mem_ack = 1'b0;
        void'(sb.pop_front());
        check("t3_count3", buf_count, 3);
        check("t3_notfull", buf_full, 0);
        tick();
        cpu_wr_req = 1'b0;
        sb.push_back('{a: 10'h3FF, d: 32'hFF});
        check("t3_count4b", buf_count, 4);
        repeat (4) ack_after(0);
        check("t3_empty", buf_empty, 1);

        // Ordering across two pointer wraps.
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == DEPTH) ack_after(int'($urandom_range(0, 5)));
            store(AW'(i), DW'(32'hC00 + i));
        end
        while (sb.size() != 0) ack_after(int'($urandom_range(0, 5)));
        check("t4_empty", buf_empty, 1);

        // Forwarding, youngest match wins.
        store(10'h020, 32'h11);
        store(10'h030, 32'h22);
        store(10'h020, 32'h33);
        ld_addr = 10'h020;
        #1;
        check("t5_hit", ld_hit, 1);
        check("t5_data", ld_data, 32'h33);
        ld_addr = 10'h040;
        #1;
        check("t5_miss", ld_hit, 0);
        check("t5_miss_d", ld_data, 0);
        ld_addr    = 10'h050;
        cpu_wr_req = 1'b1;
        cpu_addr   = 10'h050;
        cpu_wdata  = 32'h44;
        #1;
        check("t5_same_cyc", ld_hit, 0);
        tick();
        cpu_wr_req = 1'b0;
        sb.push_back('{a: 10'h050, d: 32'h44});
        check("t5_next_hit", ld_hit, 1);
        check("t5_next_d", ld_data, 32'h44);
        ld_addr = 10'h020;
        while (sb.size() != 0) ack_after(1);
        #1;
        check("t5_gone", ld_hit, 0);

        // Stray acks in IDLE and GAP.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t6_idle_cnt", buf_count, 0);
        check("t6_idle_req", mem_wr_req, 0);
        tick();
        check("t6_idle_req2", mem_wr_req, 0);
        store(10'h060, 32'h66);
        store(10'h070, 32'h77);
        check("t6_req", mem_wr_req, 1);
        mem_ack = 1'b1;
        check("t6_addr", mem_addr, sb[0].a);
        tick();
        void'(sb.pop_front());
        check("t6_gap_req", mem_wr_req, 0);
        tick();
        mem_ack = 1'b0;
        check("t6_gap_cnt", buf_count, 1);
        check("t6_reissue", mem_wr_req, 1);
        check("t6_addr2", mem_addr, 10'h070);
        ack_after(0);
        check("t6_empty", buf_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
